// File: rtl/alarm_clock_core.sv
// Alarm clock core: hh:mm:ss timekeeping with NUM_ALARMS alarm channels,
// each with its own IDLE/RINGING/SNOOZED state machine, snooze and ring timeout.
module alarm_clock_core #(
  parameter int HOUR_MOD   = 24,
  parameter int MIN_MOD    = 60,
  parameter int NUM_ALARMS = 2,
  parameter int SNOOZE_MIN = 5,
  parameter int RING_SECS  = 60,
  localparam int IW = (NUM_ALARMS > 1) ? $clog2(NUM_ALARMS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  tick,
  input  logic                  set_valid,
  input  logic [5:0]            set_hh,
  input  logic [5:0]            set_mm,
  input  logic [5:0]            set_ss,
  input  logic                  alarm_wr,
  input  logic [IW-1:0]         alarm_idx,
  input  logic [5:0]            alarm_hh,
  input  logic [5:0]            alarm_mm,
  input  logic [NUM_ALARMS-1:0] alarm_en,
  input  logic                  ack,
  input  logic                  snooze,
  output logic [5:0]            hh,
  output logic [5:0]            mm,
  output logic [5:0]            ss,
  output logic                  day_pulse,
  output logic                  set_err,
  output logic [NUM_ALARMS-1:0] ringing,
  output logic                  alarm_irq
);

  localparam logic [6:0] HMOD7 = 7'(HOUR_MOD);
  localparam logic [6:0] MMOD7 = 7'(MIN_MOD);
  localparam logic [6:0] SNZ7  = 7'(SNOOZE_MIN);
  localparam logic [5:0] H_MAX = 6'(HOUR_MOD - 1);
  localparam logic [5:0] M_MAX = 6'(MIN_MOD - 1);
  localparam logic [7:0] RLAST = 8'(RING_SECS - 1);

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} state_t;

  state_t     state [NUM_ALARMS];
  logic [5:0] al_hh [NUM_ALARMS];
  logic [5:0] al_mm [NUM_ALARMS];
  logic [5:0] sn_hh [NUM_ALARMS];
  logic [5:0] sn_mm [NUM_ALARMS];
  logic [7:0] rcnt  [NUM_ALARMS];

  logic tick_eff, set_ok, wr_ok, ss_wrap, mm_wrap, hh_wrap, min_edge;
  logic [5:0] inc_hh, inc_mm, inc_ss, snz_hh, snz_mm;
  logic [6:0] snz_sum;
  logic [NUM_ALARMS-1:0] enter;

  // Validation, next-second arithmetic, snooze target and per-channel match events
  always_comb begin
    tick_eff = tick & ~set_valid;
    set_ok   = ({1'b0, set_hh} < HMOD7) && ({1'b0, set_mm} < MMOD7) &&
               ({1'b0, set_ss} < MMOD7);
    wr_ok    = (int'(alarm_idx) < NUM_ALARMS) && ({1'b0, alarm_hh} < HMOD7) &&
               ({1'b0, alarm_mm} < MMOD7);
    ss_wrap  = (ss == M_MAX);
    mm_wrap  = (mm == M_MAX);
    hh_wrap  = (hh == H_MAX);
    inc_ss   = ss_wrap ? '0 : ss + 6'd1;
    inc_mm   = ss_wrap ? (mm_wrap ? '0 : mm + 6'd1) : mm;
    inc_hh   = (ss_wrap && mm_wrap) ? (hh_wrap ? '0 : hh + 6'd1) : hh;
    // seconds rolling over to :00 is the only way a tick lands on hh:mm:00
    min_edge = tick_eff && ss_wrap;
    snz_sum  = {1'b0, mm} + SNZ7;
    if (snz_sum >= MMOD7) begin
      snz_mm = 6'(snz_sum - MMOD7);
      snz_hh = hh_wrap ? '0 : hh + 6'd1;
    end else begin
      snz_mm = snz_sum[5:0];
      snz_hh = hh;
    end
    enter = '0;
    for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
      if (alarm_en[i]) begin
        if (state[i] == IDLE && min_edge && inc_hh == al_hh[i] && inc_mm == al_mm[i])
          enter[i] = 1'b1;
        if (state[i] == SNOOZED && !ack && min_edge &&
            inc_hh == sn_hh[i] && inc_mm == sn_mm[i])
          enter[i] = 1'b1;
      end
    end
  end

  // Current time, day rollover pulse and rejection pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hh        <= '0;
      mm        <= '0;
      ss        <= '0;
      day_pulse <= 1'b0;
      set_err   <= 1'b0;
    end else begin
      if (set_valid) begin
        if (set_ok) begin
          hh <= set_hh;
          mm <= set_mm;
          ss <= set_ss;
        end
      end else if (tick) begin
        hh <= inc_hh;
        mm <= inc_mm;
        ss <= inc_ss;
      end
      day_pulse <= tick_eff && ss_wrap && mm_wrap && hh_wrap;
      set_err   <= (set_valid && !set_ok) || (alarm_wr && !wr_ok);
    end
  end

  // Programmed alarm times
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        al_hh[i] <= '0;
        al_mm[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (alarm_wr && wr_ok && alarm_idx == IW'(i)) begin
          al_hh[i] <= alarm_hh;
          al_mm[i] <= alarm_mm;
        end
      end
    end
  end

  // Per-channel alarm state machines with registered ringing flags and irq
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        state[i] <= IDLE;
        sn_hh[i] <= '0;
        sn_mm[i] <= '0;
        rcnt[i]  <= '0;
      end
      ringing   <= '0;
      alarm_irq <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_ALARMS; i++) begin
        if (!alarm_en[i]) begin
          state[i]   <= IDLE;
          ringing[i] <= 1'b0;
        end else begin
          case (state[i])
            IDLE: begin
              if (enter[i]) begin
                state[i]   <= RINGING;
                rcnt[i]    <= '0;
                ringing[i] <= 1'b1;
              end
            end
            RINGING: begin
              if (ack) begin
                state[i]   <= IDLE;
                ringing[i] <= 1'b0;
              end else if (snooze) begin
                state[i]   <= SNOOZED;
                sn_hh[i]   <= snz_hh;
                sn_mm[i]   <= snz_mm;
                ringing[i] <= 1'b0;
              end else if (tick) begin
                if (rcnt[i] == RLAST) begin
                  state[i]   <= IDLE;
                  ringing[i] <= 1'b0;
                end else begin
                  rcnt[i] <= rcnt[i] + 8'd1;
                end
              end
            end
            SNOOZED: begin
              if (ack) begin
                state[i] <= IDLE;
              end else if (enter[i]) begin
                state[i]   <= RINGING;
                rcnt[i]    <= '0;
                ringing[i] <= 1'b1;
              end
            end
            default: begin
              state[i]   <= IDLE;
              ringing[i] <= 1'b0;
            end
          endcase
        end
      end
      alarm_irq <= |enter;
    end
  end

endmodule

// File: doc/alarm_clock_core.md
ALARM_CLOCK_CORE -- requirements
Module: alarm_clock_core

Interface
REQ-001 Parameter HOUR_MOD, default 24, hour counter modulus (1..64).
REQ-002 Parameter MIN_MOD, default 60, minute and second counter modulus (2..64).
REQ-003 Parameter NUM_ALARMS, default 2, independent alarm channels (1..8); IW = max(1, clog2(NUM_ALARMS)).
REQ-004 Parameter SNOOZE_MIN, default 5, snooze interval in minutes (1..MIN_MOD-1).
REQ-005 Parameter RING_SECS, default 60, ticks before a ringing alarm self-clears (1..255).
REQ-006 Port clk  in  1  single clock; all state on rising edge.
REQ-007 Port rst_n  in  1  asynchronous active-low reset.
REQ-008 Port tick  in  1  one-cycle pulse marking one elapsed second.
REQ-009 Port set_valid  in  1  load time from set_hh/set_mm/set_ss.
REQ-010 Port set_hh, set_mm, set_ss  in  6 each  time to load.
REQ-011 Port alarm_wr  in  1  write alarm_hh/alarm_mm into channel alarm_idx.
REQ-012 Port alarm_idx  in  IW  alarm channel select.
REQ-013 Port alarm_hh, alarm_mm  in  6 each  alarm time.
REQ-014 Port alarm_en  in  NUM_ALARMS  per-channel enable.
REQ-015 Port ack, snooze  in  1 each  user controls, applied to all ringing channels.
REQ-016 Port hh, mm, ss  out  6 each  current time, registered.
REQ-017 Port day_pulse  out  1  one-cycle pulse on hour wrap to 0.
REQ-018 Port set_err  out  1  one-cycle pulse on rejected set or alarm write.
REQ-019 Port ringing  out  NUM_ALARMS  per-channel ringing state.
REQ-020 Port alarm_irq  out  1  one-cycle pulse when any channel enters RINGING.

Function
REQ-021 On tick: ss+1; ss==MIN_MOD-1 -> ss=0, mm+1; mm==MIN_MOD-1 -> mm=0, hh+1; hh==HOUR_MOD-1 -> hh=0, day_pulse=1 next cycle; outputs visible the cycle after the tick edge.
REQ-022 set_valid loads all three fields at the next edge; set wins over a same-cycle tick (tick discarded).
REQ-023 Any set field out of range (hh>=HOUR_MOD, mm/ss>=MIN_MOD) -> entire set rejected, time unchanged, set_err pulse.
REQ-024 alarm_wr with alarm_idx>=NUM_ALARMS or out-of-range fields -> no write, set_err pulse; otherwise channel alarm time updated next edge.
REQ-025 Per-channel FSM states IDLE, RINGING, SNOOZED.
REQ-026 Match event: a tick that advances time to exactly A_hh:A_mm:00 for the channel's target; loading that time via set_valid is not a match.
REQ-027 IDLE -> RINGING on match against programmed alarm time when alarm_en[i]=1; ring counter cleared.
REQ-028 RINGING: ring counter +1 per tick; ack -> IDLE; snooze -> SNOOZED with target = current hh:mm + SNOOZE_MIN minutes, wrapping minutes into hours and hours modulo HOUR_MOD; counter reaching RING_SECS -> IDLE.
REQ-029 SNOOZED -> RINGING on match against snooze target; ack -> IDLE; snooze ignored.
REQ-030 ack and snooze in the same cycle: ack wins.
REQ-031 alarm_en[i]=0 forces channel i to IDLE next edge, any state.
REQ-032 alarm_wr to a RINGING or SNOOZED channel updates its alarm time only; state unaffected.
REQ-033 ringing[i]=1 exactly while channel i is in RINGING; alarm_irq pulses once per cycle in which one or more channels enter RINGING.

Reset
REQ-034 rst_n low asynchronously clears hh, mm, ss, all alarm times, snooze targets, ring counters to 0, all FSMs to IDLE, and day_pulse, set_err, ringing, alarm_irq to 0.
REQ-035 Reset deasserted mid-ring: channel returns to IDLE, no alarm_irq on exit from reset.

Verification
REQ-036 Time 23:59:59, tick -> 00:00:00, day_pulse high one cycle.
REQ-037 Alarm0=07:30, en=1, time 07:29:59, tick -> ringing[0]=1, alarm_irq one pulse; 60 further ticks without ack -> ringing[0]=0.
REQ-038 Alarm0 ringing at 07:30:10, snooze -> SNOOZED; ticks to 07:35:00 -> ringing again; ack -> IDLE.
REQ-039 set_valid with 24:00:00 -> set_err pulse, time unchanged; set 12:00:00 with same-cycle tick -> 12:00:00 exactly.
REQ-040 Alarm0 and alarm1 both 06:00 -> both ring together, single alarm_irq pulse; ack+snooze same cycle -> both IDLE.
REQ-041 rst_n low during RINGING at 07:30:05 -> all outputs 0 immediately; after release, time counts from 00:00:00.
